// File: rtl/cpu_dram_arb_pkg.sv
// Shared definitions for the CPU/video DRAM quad arbiter: owner states and byte-select codes.
package cpu_dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VIDEO  = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } owner_t;

    localparam logic [1:0] BSEL_NONE = 2'b00;
    localparam logic [1:0] BSEL_LO   = 2'b01;
    localparam logic [1:0] BSEL_HI   = 2'b10;
    localparam logic [1:0] BSEL_W    = 2'b11;

endpackage

// File: rtl/cpu_dram_arb_starve_cnt.sv
// Starvation counter: counts consecutive video grants that left a pending CPU request waiting.
module arb_starve_cnt #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic c3,
    input  logic grant_video,
    input  logic cpu_req,
    output logic cpu_force
);

    logic [3:0] count;

    // Every c3 is an arbitration point; anything other than a video grant over a waiting CPU resets the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (c3) begin
            if (grant_video && cpu_req) begin
                count <= count + 4'd1;
            end else begin
                count <= 4'd0;
            end
        end
    end

    assign cpu_force = (count == STARVE_MAX[3:0]);

endmodule

// File: rtl/cpu_dram_arb.sv
// CPU/video DRAM quad arbiter; the optional starvation limit is enabled by defining STARVE_LIMIT_EN.
module cpu_dram_arb
    import cpu_dram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c0,
    input  logic        c1,
    input  logic        c2,
    input  logic        c3,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic        cpu_wrbsel,
    input  logic [7:0]  cpu_wrdata,
    input  logic        video_req,
    input  logic [20:0] video_addr,
    input  logic [15:0] dram_rddata,
    output logic        cpu_next,
    output logic        cpu_strobe,
    output logic        cpu_latch,
    output logic [15:0] cpu_rddata,
    output logic        video_strobe,
    output logic        dram_req,
    output logic        dram_rnw,
    output logic [20:0] dram_addr,
    output logic [1:0]  dram_bsel,
    output logic [15:0] dram_wrdata
);

    localparam logic [1:0] RD_IDX = RD_LAT[1:0];

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("cpu_dram_arb: STARVE_MAX must be in 1..15");
    end
    if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("cpu_dram_arb: RD_LAT must be in 0..3");
    end

    owner_t     owner;
    owner_t     owner_nxt;
    logic       cpu_force;
    logic       phase_ok;
    logic [1:0] phase_idx;
    logic       at_rd;

    // A malformed strobe pattern never matches the read phase, so it cannot fake a strobe.
    always_comb begin
        phase_ok  = 1'b1;
        phase_idx = 2'd0;
        case ({c3, c2, c1, c0})
            4'b0001: phase_idx = 2'd0;
            4'b0010: phase_idx = 2'd1;
            4'b0100: phase_idx = 2'd2;
            4'b1000: phase_idx = 2'd3;
            default: phase_ok  = 1'b0;
        endcase
    end

    assign at_rd = phase_ok && (phase_idx == RD_IDX);

    always_comb begin
        owner_nxt = IDLE;
        if (video_req && !cpu_force) begin
            owner_nxt = VIDEO;
        end else if (cpu_req) begin
            owner_nxt = cpu_rnw ? CPU_RD : CPU_WR;
        end
    end

`ifdef STARVE_LIMIT_EN
    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .c3          (c3),
        .grant_video (owner_nxt == VIDEO),
        .cpu_req     (cpu_req),
        .cpu_force   (cpu_force)
    );
`else
    assign cpu_force = 1'b0;
`endif

    assign cpu_next     = !video_req || cpu_force;
    assign cpu_strobe   = (owner == CPU_RD) && at_rd;
    assign video_strobe = (owner == VIDEO) && at_rd;

    // Owner and the whole DRAM command are captured together at c3 and held for the quad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= IDLE;
            dram_req    <= 1'b0;
            dram_rnw    <= 1'b0;
            dram_addr   <= 21'd0;
            dram_bsel   <= BSEL_NONE;
            dram_wrdata <= 16'h0000;
        end else if (c3) begin
            owner <= owner_nxt;
            case (owner_nxt)
                VIDEO: begin
                    dram_req    <= 1'b1;
                    dram_rnw    <= 1'b1;
                    dram_addr   <= video_addr;
                    dram_bsel   <= BSEL_W;
                    dram_wrdata <= 16'h0000;
                end
                CPU_RD: begin
                    dram_req    <= 1'b1;
                    dram_rnw    <= 1'b1;
                    dram_addr   <= cpu_addr;
                    dram_bsel   <= BSEL_W;
                    dram_wrdata <= 16'h0000;
                end
                CPU_WR: begin
                    dram_req    <= 1'b1;
                    dram_rnw    <= 1'b0;
                    dram_addr   <= cpu_addr;
                    dram_bsel   <= cpu_wrbsel ? BSEL_HI : BSEL_LO;
                    dram_wrdata <= {cpu_wrdata, cpu_wrdata};
                end
                default: begin
                    dram_req    <= 1'b0;
                    dram_rnw    <= 1'b0;
                    dram_addr   <= 21'd0;
                    dram_bsel   <= BSEL_NONE;
                    dram_wrdata <= 16'h0000;
                end
            endcase
        end
    end

    // A fresh read result takes precedence over a clear from a CPU grant landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rddata <= 16'h0000;
            cpu_latch  <= 1'b0;
        end else begin
            if (cpu_strobe) begin
                cpu_rddata <= dram_rddata;
            end
            if (cpu_strobe) begin
                cpu_latch <= 1'b1;
            end else if (c3 && (owner_nxt == CPU_RD || owner_nxt == CPU_WR)) begin
                cpu_latch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_dram_arb.sv
// Self-checking bench for cpu_dram_arb: directed scenarios plus random traffic against a quad-level model.
module tb_cpu_dram_arb;

    localparam int STARVE_MAX = 3;
    localparam int RD_LAT     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0, c1, c2, c3;
    logic        cpu_req, cpu_rnw, cpu_wrbsel, video_req;
    logic [20:0] cpu_addr, video_addr;
    logic [7:0]  cpu_wrdata;
    logic [15:0] dram_rddata;
    logic        cpu_next, cpu_strobe, cpu_latch, video_strobe;
    logic [15:0] cpu_rddata;
    logic        dram_req, dram_rnw;
    logic [20:0] dram_addr;
    logic [1:0]  dram_bsel;
    logic [15:0] dram_wrdata;

    cpu_dram_arb #(
        .STARVE_MAX (STARVE_MAX),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .c0           (c0),
        .c1           (c1),
        .c2           (c2),
        .c3           (c3),
        .cpu_req      (cpu_req),
        .cpu_rnw      (cpu_rnw),
        .cpu_addr     (cpu_addr),
        .cpu_wrbsel   (cpu_wrbsel),
        .cpu_wrdata   (cpu_wrdata),
        .video_req    (video_req),
        .video_addr   (video_addr),
        .dram_rddata  (dram_rddata),
        .cpu_next     (cpu_next),
        .cpu_strobe   (cpu_strobe),
        .cpu_latch    (cpu_latch),
        .cpu_rddata   (cpu_rddata),
        .video_strobe (video_strobe),
        .dram_req     (dram_req),
        .dram_rnw     (dram_rnw),
        .dram_addr    (dram_addr),
        .dram_bsel    (dram_bsel),
        .dram_wrdata  (dram_wrdata)
    );

    always #5 clk = ~clk;

    // Model kinds: 0 = idle, 1 = video, 2 = cpu read, 3 = cpu write.
    int          ph;
    int          m_kind;
    logic [20:0] m_addr;
    logic [1:0]  m_bsel;
    logic [15:0] m_wrdata;
    logic [15:0] m_rddata;
    logic        m_latch;
    int          m_starve;
    int          errors;
    int          checks;
    int          rd_seen;

    function automatic bit modelForce();
`ifdef STARVE_LIMIT_EN
        return (m_starve == STARVE_MAX);
`else
        return 1'b0;
`endif
    endfunction

    task automatic driveStrobes();
        c0 = (ph == 0);
        c1 = (ph == 1);
        c2 = (ph == 2);
        c3 = (ph == 3);
    endtask

    task automatic modelReset();
        m_kind   = 0;
        m_addr   = '0;
        m_bsel   = 2'b00;
        m_wrdata = 16'h0000;
        m_rddata = 16'h0000;
        m_latch  = 1'b0;
        m_starve = 0;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit creq, input bit vreq, input bit rnw,
                                 input logic [20:0] caddr, input logic [20:0] vaddr,
                                 input bit wbsel, input logic [7:0] wdata, input logic [15:0] rdata);
        cpu_req     = creq;
        video_req   = vreq;
        cpu_rnw     = rnw;
        cpu_addr    = caddr;
        video_addr  = vaddr;
        cpu_wrbsel  = wbsel;
        cpu_wrdata  = wdata;
        dram_rddata = rdata;
    endtask

    // Work out what the coming edge does from the current inputs, then advance the phase.
    task automatic tick();
        bit          in_rst;
        int          n_kind, n_starve, g;
        logic [20:0] n_addr;
        logic [1:0]  n_bsel;
        logic [15:0] n_wrdata, n_rddata;
        logic        n_latch;
        bit          rd_now;
        in_rst   = rst;
        n_kind   = m_kind;
        n_starve = m_starve;
        n_addr   = m_addr;
        n_bsel   = m_bsel;
        n_wrdata = m_wrdata;
        n_rddata = m_rddata;
        n_latch  = m_latch;
        rd_now   = (m_kind == 2) && (ph == RD_LAT);
        if (rd_now) begin
            n_rddata = dram_rddata;
            n_latch  = 1'b1;
        end
        if (ph == 3) begin
            if (video_req && !modelForce()) g = 1;
            else if (cpu_req) g = cpu_rnw ? 2 : 3;
            else g = 0;
            n_starve = (g == 1 && cpu_req) ? m_starve + 1 : 0;
            if ((g == 2 || g == 3) && !rd_now) n_latch = 1'b0;
            n_kind   = g;
            n_addr   = (g == 1) ? video_addr : (g >= 2) ? cpu_addr : 21'd0;
            n_bsel   = (g == 1 || g == 2) ? 2'b11 : (g == 3) ? (cpu_wrbsel ? 2'b10 : 2'b01) : 2'b00;
            n_wrdata = (g == 3) ? {cpu_wrdata, cpu_wrdata} : 16'h0000;
        end
        @(posedge clk);
        if (!in_rst) begin
            m_kind   = n_kind;
            m_starve = n_starve;
            m_addr   = n_addr;
            m_bsel   = n_bsel;
            m_wrdata = n_wrdata;
            m_rddata = n_rddata;
            m_latch  = n_latch;
        end
        #1;
        ph = (ph + 1) % 4;
        driveStrobes();
    endtask

    task automatic checkOutput();
        #1;
        checkValue("dram_req",     dram_req,     (m_kind != 0));
        checkValue("dram_rnw",     dram_rnw,     (m_kind == 1 || m_kind == 2));
        checkValue("dram_addr",    dram_addr,    m_addr);
        checkValue("dram_bsel",    dram_bsel,    m_bsel);
        checkValue("dram_wrdata",  dram_wrdata,  m_wrdata);
        checkValue("cpu_strobe",   cpu_strobe,   (m_kind == 2 && ph == RD_LAT));
        checkValue("video_strobe", video_strobe, (m_kind == 1 && ph == RD_LAT));
        checkValue("cpu_latch",    cpu_latch,    m_latch);
        checkValue("cpu_rddata",   cpu_rddata,   m_rddata);
        checkValue("cpu_next",     cpu_next,     (!video_req || modelForce()));
        if (cpu_strobe === 1'b1) rd_seen++;
    endtask

    task automatic cycle();
        tick();
        checkOutput();
    endtask

    task automatic runUntil(input string tag, input int kind, input int phase, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            if (m_kind == kind && ph == phase) found = 1'b1;
        end
        checkValue(tag, found, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rd_seen = 0;
        ph = 0;
        rst = 1'b1;
        driveStrobes();
        applyStimulus(0, 0, 0, 21'd0, 21'd0, 0, 8'h00, 16'h0000);
        modelReset();
        repeat (3) cycle();

        // Release reset mid-quad; nothing may issue before the first c3.
        rst = 1'b0;
        applyStimulus(1, 0, 1, 21'h0ABCD, 21'd0, 0, 8'h00, 16'hBEEF);
        runUntil("rd_reach_c2", 2, RD_LAT, 12);
        checkValue("rd_strobe_c2", cpu_strobe, 1);
        checkValue("rd_addr", dram_addr, 21'h0ABCD);
        checkValue("rd_bsel", dram_bsel, 2'b11);
        cycle();
        checkValue("rd_data", cpu_rddata, 16'hBEEF);
        checkValue("rd_latch_c3", cpu_latch, 1);

        // CPU write, high byte.
        applyStimulus(1, 0, 0, 21'h01234, 21'd0, 1, 8'h5A, 16'h0000);
        runUntil("wr_reach", 3, 0, 12);
        checkValue("wr_bsel", dram_bsel, 2'b10);
        checkValue("wr_data", dram_wrdata, 16'h5A5A);
        checkValue("wr_rnw", dram_rnw, 0);
        checkValue("wr_latch_clear", cpu_latch, 0);
        rd_seen = 0;
        repeat (4) cycle();
        checkValue("wr_no_strobe", rd_seen, 0);
        checkValue("wr_rddata_kept", cpu_rddata, 16'hBEEF);

        // Contention: both requesters held high.
        applyStimulus(1, 1, 1, 21'h00111, 21'h1F000, 0, 8'h00, 16'hC0DE);
        rd_seen = 0;
        repeat (32) cycle();
`ifdef STARVE_LIMIT_EN
        checkValue("contention_cpu_served", (rd_seen >= 1), 1);
`else
        checkValue("contention_cpu_starved", rd_seen, 0);
        checkValue("contention_cpu_next", cpu_next, 0);
`endif

        // Reset at c1 of a CPU read quad, released before c3.
        applyStimulus(1, 0, 1, 21'h0F0F0, 21'd0, 0, 8'h00, 16'h1111);
        runUntil("rst_reach_c1", 2, 1, 24);
        rst = 1'b1;
        modelReset();
        checkOutput();
        checkValue("rst_dram_req", dram_req, 0);
        checkValue("rst_rddata", cpu_rddata, 16'h0000);
        cycle();
        checkValue("rst_no_strobe_c2", cpu_strobe, 0);
        rst = 1'b0;
        cycle();
        cycle();
        checkValue("rst_regrant", dram_req, 1);
        checkValue("rst_regrant_addr", dram_addr, 21'h0F0F0);

        // Random traffic with inputs changing freely mid-quad.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 1), ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
                          21'($urandom), 21'($urandom), $urandom_range(0, 1),
                          8'($urandom), 16'($urandom));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
